zorro_master_cycle: RTL and testbench

- Zorro III bus-master cycle sequencer: the initiator side of the cycles the buffer control logic steers transceivers for.
- When the SCSI chip is local master and the board owns the bus (MYBUS), it converts one local request into a Zorro III cycle: address phase, FCS_n, DOE/DS_n, DTACK_n/BERR_n termination.
- Read data is captured, then the local master is acknowledged.
- Sits between the SCSI local-bus interface and the Zorro pins, alongside the buffer control logic.

---
 rtl/zorro_pkg.sv | 18 +
 rtl/zorro_timeout_counter.sv | 42 ++++
 rtl/zorro_master_cycle.sv | 192 +++++++++++++++++++
 tb/tb_zorro_master_cycle.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zorro_pkg.sv
// Shared definitions for the Zorro III master-side cycle logic:
// sequencer state encoding, inactive strobe value and default timing.
package zorro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_STROBE,
        ST_WAIT,
        ST_TERM,
        ST_RECOVER
    } zorro_state_e;

    localparam logic [3:0] DS_IDLE            = 4'hF;
    localparam int         DEFAULT_TIMEOUT    = 64;
    localparam int         DEFAULT_ADDR_SETUP = 1;

endpackage

// File: rtl/zorro_timeout_counter.sv
// Saturating clear/increment counter that flags when it reaches LIMIT-1.
// Used to bound how long a bus cycle waits for the slave to respond.
module zorro_timeout_counter
    import zorro_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] SAT  = CW'(LIMIT);

    logic [CW-1:0] count_q, count_d;

    // Clear wins over increment; the count parks at LIMIT rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != SAT)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/zorro_master_cycle.sv
// Zorro III bus-master cycle sequencer: turns one local request from the
// SCSI chip into an address phase, FCS_n, DOE/DS_n and a DTACK_n/BERR_n
// (or timeout) terminated data phase, then acknowledges the local master.
module zorro_master_cycle
    import zorro_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int ADDR_SETUP     = DEFAULT_ADDR_SETUP
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MYBUS,
    input  logic        MASTER_n,
    input  logic        REQ,
    input  logic        REQ_READ,
    input  logic [31:0] REQ_ADDR,
    input  logic [3:0]  REQ_BE,
    input  logic [31:0] REQ_WDATA,
    output logic        ACK,
    output logic        ERR,
    output logic [31:0] RDATA,
    output logic [31:0] Z_ADDR,
    output logic [31:0] Z_WDATA,
    output logic        READ,
    output logic        FCS_n,
    output logic        DOE,
    output logic [3:0]  DS_n,
    input  logic [31:0] Z_DATA_IN,
    input  logic        DTACK_n,
    input  logic        BERR_n
);

    localparam logic [1:0] SETUP_LAST = 2'(ADDR_SETUP - 1);

    zorro_state_e state_q, state_d;
    logic [31:0]  z_addr_q, z_addr_d;
    logic [31:0]  z_wdata_q, z_wdata_d;
    logic [31:0]  rdata_q, rdata_d;
    logic [3:0]   be_q, be_d;
    logic [3:0]   ds_n_q, ds_n_d;
    logic [1:0]   setup_q, setup_d;
    logic         read_q, read_d;
    logic         fcs_n_q, fcs_n_d;
    logic         doe_q, doe_d;
    logic         ack_q, ack_d;
    logic         err_q, err_d;
    logic         tmo_clear, tmo_enable, tmo_expired;
    logic         bus_lost, term_go, term_err;

    assign bus_lost = !MYBUS || MASTER_n;

    zorro_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (CLK),
        .reset   (RESET),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // Next-state and strobe decode; every path into TERM releases the strobes and raises ACK together.
    always_comb begin
        state_d    = state_q;
        z_addr_d   = z_addr_q;
        z_wdata_d  = z_wdata_q;
        rdata_d    = rdata_q;
        be_d       = be_q;
        ds_n_d     = ds_n_q;
        setup_d    = setup_q;
        read_d     = read_q;
        fcs_n_d    = fcs_n_q;
        doe_d      = doe_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        tmo_clear  = 1'b0;
        tmo_enable = 1'b0;
        term_go    = 1'b0;
        term_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (REQ && MYBUS && !MASTER_n) begin
                    z_addr_d  = REQ_ADDR;
                    z_wdata_d = REQ_WDATA;
                    read_d    = REQ_READ;
                    be_d      = REQ_BE;
                    setup_d   = 2'd0;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus_lost) begin
                    term_go  = 1'b1;
                    term_err = 1'b1;
                end else if (setup_q == SETUP_LAST) begin
                    fcs_n_d = 1'b0;
                    state_d = ST_STROBE;
                end else begin
                    setup_d = setup_q + 2'd1;
                end
            end
            ST_STROBE: begin
                if (bus_lost) begin
                    term_go  = 1'b1;
                    term_err = 1'b1;
                end else begin
                    doe_d     = 1'b1;
                    ds_n_d    = ~be_q;
                    tmo_clear = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus_lost || !BERR_n) begin
                    term_go  = 1'b1;
                    term_err = 1'b1;
                end else if (!DTACK_n) begin
                    term_go = 1'b1;
                    if (read_q) begin
                        rdata_d = Z_DATA_IN;
                    end
                end else if (tmo_expired) begin
                    term_go  = 1'b1;
                    term_err = 1'b1;
                end else begin
                    tmo_enable = 1'b1;
                end
            end
            ST_TERM: begin
                state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (term_go) begin
            state_d = ST_TERM;
            fcs_n_d = 1'b1;
            doe_d   = 1'b0;
            ds_n_d  = DS_IDLE;
            ack_d   = 1'b1;
            err_d   = term_err;
        end
    end

    // Sequencer and bus-facing registers; reset drops every strobe on the next edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            z_addr_q  <= '0;
            z_wdata_q <= '0;
            rdata_q   <= '0;
            be_q      <= '0;
            ds_n_q    <= DS_IDLE;
            setup_q   <= '0;
            read_q    <= 1'b1;
            fcs_n_q   <= 1'b1;
            doe_q     <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            z_addr_q  <= z_addr_d;
            z_wdata_q <= z_wdata_d;
            rdata_q   <= rdata_d;
            be_q      <= be_d;
            ds_n_q    <= ds_n_d;
            setup_q   <= setup_d;
            read_q    <= read_d;
            fcs_n_q   <= fcs_n_d;
            doe_q     <= doe_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign ACK     = ack_q;
    assign ERR     = err_q;
    assign RDATA   = rdata_q;
    assign Z_ADDR  = z_addr_q;
    assign Z_WDATA = z_wdata_q;
    assign READ    = read_q;
    assign FCS_n   = fcs_n_q;
    assign DOE     = doe_q;
    assign DS_n    = ds_n_q;

endmodule

// File: tb/tb_zorro_master_cycle.sv
// Directed bench for zorro_master_cycle: requests push their expected
// ERR/RDATA into a queue, and a monitor pops and compares on every ACK.
module tb_zorro_master_cycle;

    logic        CLK = 1'b0;
    logic        RESET, MYBUS, MASTER_n, REQ, REQ_READ, DTACK_n, BERR_n;
    logic [31:0] REQ_ADDR, REQ_WDATA, Z_DATA_IN;
    logic [3:0]  REQ_BE;
    logic        ACK, ERR, READ, FCS_n, DOE;
    logic [31:0] RDATA, Z_ADDR, Z_WDATA;
    logic [3:0]  DS_n;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_r;
    int    total_checks = 0;
    int    bad_checks   = 0;
    int    n_cycles;

    zorro_master_cycle #(
        .TIMEOUT_CYCLES (64),
        .ADDR_SETUP     (1)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .MYBUS     (MYBUS),
        .MASTER_n  (MASTER_n),
        .REQ       (REQ),
        .REQ_READ  (REQ_READ),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_BE    (REQ_BE),
        .REQ_WDATA (REQ_WDATA),
        .ACK       (ACK),
        .ERR       (ERR),
        .RDATA     (RDATA),
        .Z_ADDR    (Z_ADDR),
        .Z_WDATA   (Z_WDATA),
        .READ      (READ),
        .FCS_n     (FCS_n),
        .DOE       (DOE),
        .DS_n      (DS_n),
        .Z_DATA_IN (Z_DATA_IN),
        .DTACK_n   (DTACK_n),
        .BERR_n    (BERR_n)
    );

    // Free-running 100 MHz clock.
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] wdata, input bit expect_resp,
                                 input logic exp_err, input logic [31:0] exp_rdata);
        resp_t r;
        REQ_READ  = rd;
        REQ_ADDR  = addr;
        REQ_BE    = be;
        REQ_WDATA = wdata;
        REQ       = 1'b1;
        if (expect_resp) begin
            r.err   = exp_err;
            r.rdata = exp_rdata;
            exp_q.push_back(r);
        end
    endtask

    task automatic waitAck(input int max_cycles, output int n);
        n = 0;
        while ((ACK !== 1'b1) && (n < max_cycles)) begin
            tick();
            n++;
        end
        checkOutput("ack_within_bound", 32'(ACK), 32'd1);
    endtask

    // Scoreboard monitor: every ACK must match the oldest outstanding expectation.
    always @(posedge CLK) begin
        #1;
        if (ACK === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_checks++;
                bad_checks++;
                $display("[TB] FAIL unexpected_ack: got ACK=1, wanted no ACK");
            end else begin
                mon_r = exp_q.pop_front();
                checkOutput("sb_err", 32'(ERR), 32'(mon_r.err));
                checkOutput("sb_rdata", RDATA, mon_r.rdata);
            end
        end
    end

    // Hard stop in case the stimulus itself wedges.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        RESET     = 1'b1;
        MYBUS     = 1'b1;
        MASTER_n  = 1'b0;
        REQ       = 1'b0;
        REQ_READ  = 1'b1;
        REQ_ADDR  = '0;
        REQ_BE    = '0;
        REQ_WDATA = '0;
        Z_DATA_IN = 32'hDEADBEEF;
        DTACK_n   = 1'b1;
        BERR_n    = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        checkOutput("rst_fcs", 32'(FCS_n), 32'd1);
        checkOutput("rst_ds", 32'(DS_n), 32'hF);
        checkOutput("rst_doe", 32'(DOE), 32'd0);
        checkOutput("rst_read", 32'(READ), 32'd1);
        checkOutput("rst_ack", 32'(ACK), 32'd0);
        checkOutput("rst_err", 32'(ERR), 32'd0);
        checkOutput("rst_addr", Z_ADDR, 32'd0);
        checkOutput("rst_wdata", Z_WDATA, 32'd0);
        checkOutput("rst_rdata", RDATA, 32'd0);

        $display("[TB] read, DTACK on second WAIT clock");
        applyStimulus(1'b1, 32'h4000_0010, 4'hF, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        tick();
        checkOutput("rd_addr", Z_ADDR, 32'h4000_0010);
        checkOutput("rd_read_addr", 32'(READ), 32'd1);
        checkOutput("rd_fcs_addr", 32'(FCS_n), 32'd1);
        tick();
        checkOutput("rd_fcs_low", 32'(FCS_n), 32'd0);
        checkOutput("rd_doe_strobe", 32'(DOE), 32'd0);
        tick();
        checkOutput("rd_doe", 32'(DOE), 32'd1);
        checkOutput("rd_ds", 32'(DS_n), 32'h0);
        checkOutput("rd_read_wait", 32'(READ), 32'd1);
        tick();
        checkOutput("rd_no_ack_yet", 32'(ACK), 32'd0);
        DTACK_n = 1'b0;
        tick();
        checkOutput("rd_ack", 32'(ACK), 32'd1);
        checkOutput("rd_term_fcs", 32'(FCS_n), 32'd1);
        checkOutput("rd_term_ds", 32'(DS_n), 32'hF);
        checkOutput("rd_read_term", 32'(READ), 32'd1);
        REQ     = 1'b0;
        DTACK_n = 1'b1;
        tick();
        checkOutput("rd_ack_pulse", 32'(ACK), 32'd0);
        tick();

        $display("[TB] write, BE=0011");
        DTACK_n = 1'b0;
        applyStimulus(1'b0, 32'h4000_0020, 4'b0011, 32'h1234_5678, 1'b1, 1'b0, 32'hDEADBEEF);
        tick();
        checkOutput("wr_read", 32'(READ), 32'd0);
        checkOutput("wr_wdata_addr", Z_WDATA, 32'h1234_5678);
        tick();
        tick();
        checkOutput("wr_ds", 32'(DS_n), 32'hC);
        checkOutput("wr_ack_early", 32'(ACK), 32'd0);
        tick();
        checkOutput("wr_ack", 32'(ACK), 32'd1);
        checkOutput("wr_wdata_ack", Z_WDATA, 32'h1234_5678);
        checkOutput("wr_read_ack", 32'(READ), 32'd0);
        REQ     = 1'b0;
        DTACK_n = 1'b1;
        tick();
        tick();

        $display("[TB] timeout with DTACK_n held high");
        applyStimulus(1'b1, 32'h4000_0030, 4'hF, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF);
        tick();
        tick();
        tick();
        checkOutput("to_doe", 32'(DOE), 32'd1);
        waitAck(200, n_cycles);
        checkOutput("to_wait_clocks", 32'(n_cycles), 32'd64);
        checkOutput("to_fcs", 32'(FCS_n), 32'd1);
        checkOutput("to_doe_off", 32'(DOE), 32'd0);
        checkOutput("to_ds", 32'(DS_n), 32'hF);
        REQ = 1'b0;
        tick();
        tick();

        $display("[TB] BERR_n and DTACK_n together");
        Z_DATA_IN = 32'hCAFE_F00D;
        applyStimulus(1'b1, 32'h4000_0040, 4'hF, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF);
        tick();
        tick();
        tick();
        BERR_n  = 1'b0;
        DTACK_n = 1'b0;
        tick();
        checkOutput("be_ack", 32'(ACK), 32'd1);
        BERR_n  = 1'b1;
        DTACK_n = 1'b1;
        REQ     = 1'b0;
        tick();
        tick();

        $display("[TB] MYBUS lost during WAIT, REQ held");
        Z_DATA_IN = 32'h55AA_1234;
        applyStimulus(1'b1, 32'h4000_0050, 4'hF, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF);
        tick();
        tick();
        tick();
        MYBUS = 1'b0;
        tick();
        checkOutput("mb_ack", 32'(ACK), 32'd1);
        checkOutput("mb_fcs", 32'(FCS_n), 32'd1);
        tick();
        checkOutput("mb_recover_ack", 32'(ACK), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("mb_idle_fcs", 32'(FCS_n), 32'd1);
        end
        DTACK_n = 1'b0;
        MYBUS   = 1'b1;
        applyStimulus(1'b1, 32'h4000_0050, 4'hF, 32'h0, 1'b1, 1'b0, 32'h55AA_1234);
        waitAck(20, n_cycles);
        checkOutput("mb_retry_latency", 32'(n_cycles), 32'd4);
        REQ     = 1'b0;
        DTACK_n = 1'b1;
        tick();
        tick();

        $display("[TB] reset pulsed during WAIT");
        applyStimulus(1'b1, 32'h4000_0060, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        checkOutput("rs_fcs_before", 32'(FCS_n), 32'd0);
        RESET = 1'b1;
        tick();
        checkOutput("rs_fcs", 32'(FCS_n), 32'd1);
        checkOutput("rs_ds", 32'(DS_n), 32'hF);
        checkOutput("rs_doe", 32'(DOE), 32'd0);
        checkOutput("rs_ack", 32'(ACK), 32'd0);
        checkOutput("rs_rdata", RDATA, 32'd0);
        RESET = 1'b0;
        REQ   = 1'b0;
        tick();

        $display("[TB] write with no byte enables");
        DTACK_n = 1'b0;
        applyStimulus(1'b0, 32'h4000_0070, 4'h0, 32'hAABB_CCDD, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        checkOutput("be0_doe", 32'(DOE), 32'd1);
        checkOutput("be0_ds", 32'(DS_n), 32'hF);
        checkOutput("be0_wdata", Z_WDATA, 32'hAABB_CCDD);
        tick();
        checkOutput("be0_ack", 32'(ACK), 32'd1);
        REQ     = 1'b0;
        DTACK_n = 1'b1;
        tick();
        tick();

        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
